// File: rtl/app_pkg.sv
// Shared definitions for the APP channel TOT timestamper: constants,
// the FIFO record layout and the pairing FSM state encoding.
package app_pkg;

    localparam int APP_NSLOT = 8;
    localparam int SLOT_W    = 3;
    localparam int TS_W      = 16;
    localparam int WIDTH_W   = 12;
    localparam logic [WIDTH_W-1:0] WIDTH_SAT = 12'hFFF;

    // One TOT record; packs to [31] to_flag, [30:28] slot, [27:16] width, [15:0] t_rise
    typedef struct packed {
        logic                to_flag;
        logic [SLOT_W-1:0]   slot;
        logic [WIDTH_W-1:0]  width;
        logic [TS_W-1:0]     t_rise;
    } app_evt_t;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } app_state_t;

    // Clamp a raw 16-bit timestamp difference into the 12-bit width field
    function automatic logic [WIDTH_W-1:0] sat_width(input logic [TS_W-1:0] diff);
        logic [WIDTH_W-1:0] res;
        if (diff > TS_W'(WIDTH_SAT)) begin
            res = WIDTH_SAT;
        end else begin
            res = diff[WIDTH_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/app_tot_timestamper_if.sv
// Readout-side bundle: show-ahead record port plus the pop request.
interface app_tot_timestamper_if;
    import app_pkg::*;

    logic     read_en;
    logic     evt_valid;
    app_evt_t evt_data;
    logic     fifo_full;

    modport master (output read_en, input evt_valid, input evt_data, input fifo_full);
    modport slave  (input read_en, output evt_valid, output evt_data, output fifo_full);

endinterface

// File: rtl/app_evt_fifo.sv
// Synchronous show-ahead record FIFO. The head is visible whenever it is
// valid; a push into a full FIFO succeeds only when a pop frees the slot in
// the same cycle, otherwise it is dropped and flagged for one cycle.
module app_evt_fifo
    import app_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = app_evt_t
) (
    input  logic clk,
    input  logic rst_init,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_valid,
    output logic o_full,
    output logic o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_valid;
    logic           r_full;
    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_count_nxt;

    assign w_pop   = i_pop & r_valid;
    assign w_push  = i_push & (~r_full | w_pop);
    assign o_drop  = i_push & r_full & ~w_pop;
    assign o_valid = r_valid;
    assign o_full  = r_full;
    assign o_data  = r_valid ? r_mem[r_rptr] : T'('0);

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Pointers, occupancy and the registered valid/full flags
    always_ff @(posedge clk) begin
        if (rst_init) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != CW'(0));
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage write; contents need no reset because reads are gated by valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/app_tot_timestamper.sv
// Timestamps the synchronized TAC front/back pulses of one APP channel,
// pairs them in slot order into TOT records, and closes a slot that stays
// open too long by pulsing the channel's timeout input.
module app_tot_timestamper
    import app_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_init,
    input  logic [APP_NSLOT-1:0] VP_front,
    input  logic [APP_NSLOT-1:0] VP_back,
    output logic                 timeout,
    output logic                 overflow,
    output logic                 seq_err,
    app_tot_timestamper_if.slave rd
);

    localparam logic [WIDTH_W-1:0] TO_LAST  = WIDTH_W'(TIMEOUT_CYC - 1);
    localparam logic [WIDTH_W-1:0] TO_WIDTH =
        (TIMEOUT_CYC > 4095) ? WIDTH_SAT : WIDTH_W'(TIMEOUT_CYC);

    logic [2*APP_NSLOT-1:0] w_raw;
    logic [2*APP_NSLOT-1:0] w_det;
    logic [APP_NSLOT-1:0]   w_f_det;
    logic [APP_NSLOT-1:0]   w_b_det;
    logic [APP_NSLOT-1:0]   w_exp_mask;

    app_state_t             r_state;
    app_state_t             w_state_nxt;
    logic [SLOT_W-1:0]      r_exp;
    logic [SLOT_W-1:0]      w_exp_nxt;
    logic [TS_W-1:0]        r_trise;
    logic [TS_W-1:0]        w_trise_nxt;
    logic [WIDTH_W-1:0]     r_cnt;
    logic [WIDTH_W-1:0]     w_cnt_nxt;
    logic [TS_W-1:0]        r_ts;
    logic                   r_seq_err;
    logic                   r_overflow;

    logic                   w_push;
    app_evt_t               w_rec;
    logic                   w_timeout;
    logic                   w_seq_set;
    logic                   w_drop;

    assign w_raw = {VP_back, VP_front};

    for (genvar g = 0; g < 2*APP_NSLOT; g++) begin : g_sync
        logic [2:0] r_sh;
        // Two-stage synchronizer plus one history stage for rising-edge detection
        always_ff @(posedge clk) begin
            if (rst_init) begin
                r_sh <= 3'b000;
            end else begin
                r_sh <= {r_sh[1:0], w_raw[g]};
            end
        end
        assign w_det[g] = r_sh[1] & ~r_sh[2];
    end

    assign w_f_det    = w_det[APP_NSLOT-1:0];
    assign w_b_det    = w_det[2*APP_NSLOT-1:APP_NSLOT];
    assign w_exp_mask = APP_NSLOT'(1) << r_exp;

    // Pairing FSM: opens the expected slot on its front, closes it on its back or on timeout
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_trise_nxt = r_trise;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_rec       = '0;
        w_timeout   = 1'b0;
        w_seq_set   = 1'b0;
        case (r_state)
            IDLE: begin
                w_seq_set = |(w_f_det & ~w_exp_mask);
                if (w_f_det[r_exp]) begin
                    if (w_b_det[r_exp]) begin
                        // Front and back in one cycle: zero-width record, slot never opens
                        w_push    = 1'b1;
                        w_rec     = '{to_flag: 1'b0, slot: r_exp, width: '0, t_rise: r_ts};
                        w_exp_nxt = r_exp + SLOT_W'(1);
                    end else begin
                        w_state_nxt = OPEN;
                        w_trise_nxt = r_ts;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OPEN: begin
                w_seq_set = |w_f_det;
                w_cnt_nxt = r_cnt + WIDTH_W'(1);
                if (w_b_det[r_exp]) begin
                    // A back in the final cycle still beats the timeout
                    w_push      = 1'b1;
                    w_rec       = '{to_flag: 1'b0, slot: r_exp,
                                    width: sat_width(r_ts - r_trise), t_rise: r_trise};
                    w_exp_nxt   = r_exp + SLOT_W'(1);
                    w_state_nxt = IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_push      = 1'b1;
                    w_rec       = '{to_flag: 1'b1, slot: r_exp, width: TO_WIDTH, t_rise: r_trise};
                    w_exp_nxt   = r_exp + SLOT_W'(1);
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OPEN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, expected slot, rise timestamp and open-time counter
    always_ff @(posedge clk) begin
        if (rst_init) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_trise <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_trise <= w_trise_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Free-running timestamp, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst_init) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst_init) begin
            r_seq_err  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_seq_err  <= r_seq_err | w_seq_set;
            r_overflow <= r_overflow | w_drop;
        end
    end

    app_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (app_evt_t)
    ) u_fifo (
        .clk      (clk),
        .rst_init (rst_init),
        .i_push   (w_push),
        .i_data   (w_rec),
        .i_pop    (rd.read_en),
        .o_data   (rd.evt_data),
        .o_valid  (rd.evt_valid),
        .o_full   (rd.fifo_full),
        .o_drop   (w_drop)
    );

    // A reset cycle must never present a timeout to the analog channel
    assign timeout  = w_timeout & ~rst_init;
    assign overflow = r_overflow;
    assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_app_tot_timestamper.sv
// Randomized scoreboard bench for app_tot_timestamper. Stimulus tasks decide
// from the pairing rules which record (if any) each front/back pair must
// produce and queue it; a negedge monitor compares every popped record and
// every timeout pulse against those queues.
module tb_app_tot_timestamper;
    import app_pkg::*;

    localparam int T_CYC = 100;
    localparam int DEPTH = 8;
    localparam int LAT   = 2;   // cycles from a drive after posedge to its detect cycle

    logic       clk = 1'b0;
    logic       rst_init;
    logic [7:0] VP_front;
    logic [7:0] VP_back;
    logic       timeout;
    logic       overflow;
    logic       seq_err;

    app_tot_timestamper_if u_if();

    app_tot_timestamper #(.TIMEOUT_CYC(T_CYC), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_init (rst_init),
        .VP_front (VP_front),
        .VP_back  (VP_back),
        .timeout  (timeout),
        .overflow (overflow),
        .seq_err  (seq_err),
        .rd       (u_if.slave)
    );

    always #5 clk = ~clk;

    // Bench view of the timestamp: cycles since reset release, mod 2^16
    int unsigned cyc;
    always @(posedge clk) begin
        if (rst_init) cyc <= 0;
        else          cyc <= (cyc + 1) % 65536;
    end

    logic [31:0] exp_q[$];
    int unsigned to_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int m_slot = 0;   // slot the channel is expected to open next
    int m_occ  = 0;   // records the FIFO should hold
    bit m_seq  = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic logic [31:0] mk_rec(input bit to, input int slot, input int width,
                                           input int unsigned trise);
        logic [31:0] r;
        int w;
        w = (width > 4095) ? 4095 : width;
        r = {to, 3'(slot), 12'(w), 16'(trise % 65536)};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_model(input logic [31:0] rec, input bit pop_at_push);
        if (m_occ < DEPTH || pop_at_push) begin
            exp_q.push_back(rec);
            m_occ++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Front on 'slot', back 'width' cycles later; records what the channel must report
    task automatic do_pair(input int slot, input int width, input bit pop_at_push);
        int unsigned c0;
        c0 = cyc;
        if (slot != m_slot) begin
            m_seq = 1'b1;
        end else if (width <= T_CYC) begin
            push_model(mk_rec(1'b0, slot, width, c0 + LAT), pop_at_push);
            m_slot = (m_slot + 1) % 8;
        end else begin
            push_model(mk_rec(1'b1, slot, T_CYC, c0 + LAT), 1'b0);
            to_q.push_back((c0 + LAT + T_CYC) % 65536);
            m_slot = (m_slot + 1) % 8;
        end
        for (int k = 0; k < width + 6; k++) begin
            VP_front[slot] = (k < 3);
            VP_back[slot]  = (k >= width) && (k < width + 3);
            if (pop_at_push) u_if.read_en = (k == width + 2);
            wait_cyc(1);
        end
        VP_front[slot] = 1'b0;
        VP_back[slot]  = 1'b0;
    endtask

    // Monitor: compare every popped record and every timeout pulse
    always @(negedge clk) begin
        if (u_if.evt_valid === 1'b1 && u_if.read_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_record: got %h, required none", u_if.evt_data);
            end else begin
                check("record", u_if.evt_data, exp_q.pop_front());
                m_occ--;
            end
        end
        if (timeout === 1'b1) begin
            if (to_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_timeout: got pulse at ts %0d, required none", cyc);
            end else begin
                check("timeout_cycle", cyc, to_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_timeout"},   {31'd0, timeout},        32'd0);
        check({tag, "_evt_valid"}, {31'd0, u_if.evt_valid}, 32'd0);
        check({tag, "_evt_data"},  u_if.evt_data,           32'd0);
        check({tag, "_fifo_full"}, {31'd0, u_if.fifo_full}, 32'd0);
        check({tag, "_overflow"},  {31'd0, overflow},       32'd0);
        check({tag, "_seq_err"},   {31'd0, seq_err},        32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int s;
        int unsigned c0;
        rst_init     = 1'b1;
        VP_front     = 8'h00;
        VP_back      = 8'h00;
        u_if.read_en = 1'b0;
        wait_cyc(3);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_init     = 1'b0;
        u_if.read_en = 1'b1;

        // Single pair: front at ts 98 is detected at ts 100, width 50
        for (int i = 0; i < 200 && cyc != 98; i++) wait_cyc(1);
        do_pair(0, 50, 1'b0);

        // In-order pairs across all slots, including the wrap back to the start
        for (int i = 0; i < 9; i++) do_pair(m_slot, 10 * ((i % 8) + 1), 1'b0);

        // Boundaries: zero width, back exactly on the timeout cycle, one past it
        do_pair(m_slot, 0, 1'b0);
        do_pair(m_slot, T_CYC, 1'b0);
        do_pair(m_slot, T_CYC + 1, 1'b0);
        do_pair(m_slot, T_CYC + 15, 1'b0);
        wait_cyc(2);
        check("seq_err_after_late_back", {31'd0, seq_err}, 32'd0);

        // Out-of-order front: flagged, no record, channel still pairs normally
        do_pair((m_slot + 3) % 8, 12, 1'b0);
        wait_cyc(2);
        check("seq_err_set", {31'd0, seq_err}, 32'd1);
        check("no_record_after_seq", {31'd0, u_if.evt_valid}, 32'd0);
        do_pair(m_slot, 17, 1'b0);

        // Random traffic with occasional wrong slots and timeouts
        for (int i = 0; i < 25; i++) begin
            s = ($urandom_range(0, 9) == 0) ? (m_slot + 1 + $urandom_range(0, 6)) % 8 : m_slot;
            w = $urandom_range(0, T_CYC + 10);
            do_pair(s, w, 1'b0);
            wait_cyc($urandom_range(0, 4));
        end
        wait_cyc(4);
        check("seq_err_random", {31'd0, seq_err}, {31'd0, m_seq});

        // Fill the FIFO, push while popping, then push into a full FIFO
        u_if.read_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_pair(m_slot, $urandom_range(1, 30), 1'b0);
        check("full_after_fill", {31'd0, u_if.fifo_full}, 32'd1);
        do_pair(m_slot, $urandom_range(1, 30), 1'b1);
        check("full_after_push_pop", {31'd0, u_if.fifo_full}, 32'd1);
        check("no_ovf_push_pop", {31'd0, overflow}, 32'd0);
        do_pair(m_slot, $urandom_range(1, 30), 1'b0);
        check("overflow_set", {31'd0, overflow}, {31'd0, m_ovf});
        u_if.read_en = 1'b1;
        wait_cyc(DEPTH + 4);
        check("drained_valid", {31'd0, u_if.evt_valid}, 32'd0);
        check("drained_queue", exp_q.size(), 32'd0);

        // Reset while a slot is open and three records are buffered
        for (int i = 0; i < 8 && m_slot != 7; i++) do_pair(m_slot, 5, 1'b0);
        wait_cyc(3);
        u_if.read_en = 1'b0;
        for (int i = 0; i < 3; i++) do_pair(m_slot, $urandom_range(2, 20), 1'b0);
        c0 = cyc;
        VP_front[m_slot] = 1'b1;
        wait_cyc(3);
        VP_front = 8'h00;
        wait_cyc(10);
        rst_init = 1'b1;
        wait_cyc(1);
        exp_q.delete();
        to_q.delete();
        m_slot = 0;
        m_occ  = 0;
        m_seq  = 1'b0;
        m_ovf  = 1'b0;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_init     = 1'b0;
        u_if.read_en = 1'b1;
        wait_cyc(T_CYC + 20);
        check("post_reset_empty", {31'd0, u_if.evt_valid}, 32'd0);
        do_pair(m_slot, 7, 1'b0);
        wait_cyc(4);
        check("final_records_left", exp_q.size(), 32'd0);
        check("final_timeouts_left", to_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/app_tot_timestamper.md
# app_tot_timestamper

- Downstream consumer of one APP analog channel's TAC outputs.
- Synchronizes the asynchronous per-event `VP_front`/`VP_back` pulses into the `clk` domain and timestamps each edge against a free-running counter.
- Pairs each front with its back into a time-over-threshold (TOT) record and buffers records in a FIFO for the readout logic.
- Drives the channel's `timeout` input when a TOT stays open too long, so the analog channel state machine can never hang.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1000: clk cycles a slot may stay open before `timeout` fires. Legal range 2..4095.
- `FIFO_DEPTH`, default 8: record FIFO depth. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_init`  in  1  synchronous, active-high reset.
- `VP_front`  in  8  asynchronous TAC pulses, one per event slot; a rising edge marks the TOT rising edge.
- `VP_back`  in  8  asynchronous TAC pulses, one per slot; a rising edge marks the TOT falling edge.
- `read_en`  in  1  pop request from readout.
- `timeout`  out  1  one-cycle pulse to the analog channel.
- `evt_valid`  out  1  FIFO not empty.
- `evt_data`  out  32  head record (show-ahead).
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` records.
- `overflow`  out  1  sticky: a record was dropped.
- `seq_err`  out  1  sticky: a front edge arrived on an unexpected slot.

## Operation
- **Reset values.** All outputs are 0. Timestamp counter = 0, `exp_slot` = 0, FSM = IDLE, FIFO empty. Sticky flags clear only on reset.
- **Synchronization.** Each `VP_front`/`VP_back` bit passes through a 2-FF synchronizer, then a rising-edge detector (`f_det[i]`, `b_det[i]`).
- **Timestamp.** `ts` is a 16-bit free-running counter that wraps 0xFFFF→0.
- **Record format.** [31] `to_flag`, [30:28] slot, [27:16] width, [15:0] `t_rise`.
- **Width.** width = (`t_fall` − `t_rise`) mod 2^16, saturated to 0xFFF.
- **FSM state IDLE:**
  - `f_det[exp_slot]` → latch `t_rise`=`ts`, clear `to_cnt`, go to OPEN.
  - Any `f_det[j]` with j≠`exp_slot` → set `seq_err` and ignore that edge. If it coincides with `f_det[exp_slot]`, the expected slot is still opened.
  - All `b_det` are ignored in IDLE.
- **FSM state OPEN** (`to_cnt` increments every cycle):
  - `b_det[exp_slot]` → push {0, `exp_slot`, width, `t_rise`}, `exp_slot`++ (mod 8), go to IDLE.
  - Else if `to_cnt`==`TIMEOUT_CYC`−1 → pulse `timeout`, push {1, `exp_slot`, `TIMEOUT_CYC` saturated to 12 bits, `t_rise`}, `exp_slot`++, go to IDLE.
  - If back detection and timeout coincide, the back wins and no timeout is issued.
  - `f_det` in OPEN on any slot sets `seq_err` and is otherwise ignored.
- **Same-cycle front and back.** If `f_det` and `b_det` of the expected slot are detected in the same cycle while IDLE, the front opens the slot and the back is consumed in the same cycle. A record with width 0 is pushed and the FSM stays IDLE with `exp_slot`++.
- **Late backs.** A `VP_back` for a slot already closed by timeout arrives while that slot is no longer expected and is ignored silently.
- **FIFO pop.** Pop when `read_en && evt_valid`. `read_en` on empty has no effect.
- **FIFO push when full:**
  - With a simultaneous pop, both occur and the occupancy is unchanged.
  - Without a pop, the record is dropped and `overflow` is set.
- **Reset mid-operation.** An open slot is discarded, FIFO contents are lost, and no `timeout` is emitted.

## Timing
- **Edge to detection.** An async edge is seen by `f_det`/`b_det` 2–3 cycles after it occurs, depending on sampling phase. The timestamp is `ts` in the detect cycle, so both edges carry the same synchronizer offset and the width is exact to ±1 cycle.
- **Back to record.** `b_det` in cycle N → push in cycle N → `evt_valid`/`evt_data` updated in cycle N+1.
- **Timeout.** `timeout` is high for exactly one cycle, cycle N+`TIMEOUT_CYC`, where N is the front detect cycle. The record appears in cycle N+`TIMEOUT_CYC`+1.
- **Pop.** `evt_data` shows the next record the cycle after a pop. `fifo_full` and `evt_valid` are registered.
- **Throughput.** One record per cycle maximum. A back and the next front of the following slot may be detected in the same cycle; the front is then honoured from IDLE in the next cycle only if its pulse is still being detected. Minimum spacing is therefore 1 cycle between a slot's back and the next slot's front.

## Structure
- Shared package `app_pkg` holds:
  - constants: `APP_NSLOT`=8, `TS_W`=16, `WIDTH_W`=12, `WIDTH_SAT`=12'hFFF;
  - the record typedef `app_evt_t` with fields `to_flag`, `slot`, `width`, `t_rise`;
  - the FSM state enum {IDLE, OPEN}.
- Sub-module `app_evt_fifo` is a synchronous show-ahead FIFO parameterized by depth and `app_evt_t`, with push, pop, full, empty and a push-when-full drop indication.
- The synchronizer is instantiated 16× inline as a generate loop; it gets no separate module.

## Test plan
1. Reset, then `VP_front[0]` at `ts`=100 and `VP_back[0]` 50 cycles later → one record {0, 0, 50, 103±1}; `exp_slot`=1.
2. Eight in-order front/back pairs with widths 10..80 → eight records with slots 0..7, then slot 0 accepted again (wrap).
3. `TIMEOUT_CYC`=20, front[0] with no back → `timeout` high 1 cycle, 20 cycles after detect; record {1, 0, 20, t}. A late `VP_back[0]` produces no record and leaves `seq_err`=0.
4. Front on slot 3 while `exp_slot`=0 → `seq_err`=1 with no record. A subsequent slot-0 pair still records normally.
5. `FIFO_DEPTH`=8 filled, `read_en`=0, one more pair → `overflow`=1 and the 8 original records read back unchanged. Push with simultaneous pop while full → occupancy stays at 8 and `overflow` is not newly set.
6. `rst_init` asserted while slot 2 is open and the FIFO holds 3 records → all outputs 0 next cycle, no `timeout` pulse, and the next record has slot 0.
